// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, default word length and the
// receiver FSM state type.
package spi_pkg;

    // SPI modes expressed as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int unsigned SPI_BITS_LEN_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with a third flop holding
// the previous synced level so single-cycle rise/fall pulses can be derived.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic sysclk_p,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next-state of the synchroniser chain and the edge-detect history flop
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Chain registers, reset to the pin's idle level
    always_ff @(posedge sysclk_p or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversamples SCLK/MOSI/SS on sysclk_p, deserialises
// MSB-first words and checks that consecutive words increment by one.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned BITS_LEN = SPI_BITS_LEN_DEF,
    parameter logic        CPOL     = 1'b0,
    parameter logic        CPHA     = 1'b0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                sysclk_p,
    input  logic                rst_n,
    input  logic                spi_sclk_i,
    input  logic                spi_mosi_i,
    input  logic                spi_ss_i,
    output logic [BITS_LEN-1:0] spi_rdata_o,
    output logic                spi_rxvalid_o,
    output logic                seq_err_o,
    output logic [CNT_W-1:0]    rx_cnt_o,
    output logic [CNT_W-1:0]    err_cnt_o,
    output logic [7:0]          LED
);

    localparam int unsigned        BCW      = $clog2(BITS_LEN);
    localparam logic [BCW-1:0]     LAST_BIT = BCW'(BITS_LEN - 1);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic ss_s, ss_rise_unused, ss_fall_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic sample;

    spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sclk (
        .sysclk_p (sysclk_p),
        .rst_n    (rst_n),
        .d_i      (spi_sclk_i),
        .q_o      (sclk_lvl_unused),
        .rise_o   (sclk_rise),
        .fall_o   (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .sysclk_p (sysclk_p),
        .rst_n    (rst_n),
        .d_i      (spi_ss_i),
        .q_o      (ss_s),
        .rise_o   (ss_rise_unused),
        .fall_o   (ss_fall_unused)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .sysclk_p (sysclk_p),
        .rst_n    (rst_n),
        .d_i      (spi_mosi_i),
        .q_o      (mosi_s),
        .rise_o   (mosi_rise_unused),
        .fall_o   (mosi_fall_unused)
    );

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge
    assign sample = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;

    spi_state_e          state_q, state_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [BITS_LEN-1:0] shift_q, shift_d;
    logic [BITS_LEN-1:0] rdata_q, rdata_d;
    logic                valid_q, valid_d;
    logic                seq_err_q, seq_err_d;
    logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [BITS_LEN-1:0] exp_q, exp_d;
    logic                seeded_q, seeded_d;

    // Next-state, deserialiser and sequence-check logic
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        valid_d   = 1'b0;
        seq_err_d = 1'b0;
        rx_cnt_d  = rx_cnt_q;
        err_cnt_d = err_cnt_q;
        exp_d     = exp_q;
        seeded_d  = seeded_q;
        unique case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                shift_d   = '0;
                if (!ss_s) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sample) shift_d = {shift_q[BITS_LEN-2:0], mosi_s};
                // A final edge coinciding with SS release still completes the word
                if (sample && bit_cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end else if (ss_s) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else if (sample) begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            ST_DONE: begin
                rdata_d   = shift_q;
                valid_d   = 1'b1;
                rx_cnt_d  = rx_cnt_q + CNT_W'(1);
                if (seeded_q && shift_q != exp_q) begin
                    seq_err_d = 1'b1;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                exp_d     = shift_q + BITS_LEN'(1);
                seeded_d  = 1'b1;
                bit_cnt_d = '0;
                shift_d   = '0;
                state_d   = ss_s ? ST_IDLE : ST_SHIFT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge sysclk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            seq_err_q <= 1'b0;
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
            exp_q     <= '0;
            seeded_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            seq_err_q <= seq_err_d;
            rx_cnt_q  <= rx_cnt_d;
            err_cnt_q <= err_cnt_d;
            exp_q     <= exp_d;
            seeded_q  <= seeded_d;
        end
    end

    assign spi_rdata_o   = rdata_q;
    assign spi_rxvalid_o = valid_q;
    assign seq_err_o     = seq_err_q;
    assign rx_cnt_o      = rx_cnt_q;
    assign err_cnt_o     = err_cnt_q;

    if (BITS_LEN >= 8) begin : g_led_trunc
        assign LED = rdata_q[7:0];
    end else begin : g_led_ext
        assign LED = {{(8 - BITS_LEN){1'b0}}, rdata_q};
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: three instances (modes 0, 3, 1) driven
// by directed SPI frames; a monitor pops expected words on each valid pulse.
module tb_spi_slave_rx;

    localparam int H = 6;   // SCLK half period in sysclk cycles

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       sclk [3];
    logic       mosi [3];
    logic       ss   [3];
    logic [7:0] rdata[3];
    logic [7:0] led  [3];
    logic       valid[3];
    logic       serr [3];
    logic [15:0] rxc [3];
    logic [15:0] erc [3];

    spi_slave_rx #(.BITS_LEN(8), .CPOL(1'b0), .CPHA(1'b0), .CNT_W(16)) u_dut0 (
        .sysclk_p(clk), .rst_n(rst_n), .spi_sclk_i(sclk[0]), .spi_mosi_i(mosi[0]),
        .spi_ss_i(ss[0]), .spi_rdata_o(rdata[0]), .spi_rxvalid_o(valid[0]),
        .seq_err_o(serr[0]), .rx_cnt_o(rxc[0]), .err_cnt_o(erc[0]), .LED(led[0]));

    spi_slave_rx #(.BITS_LEN(8), .CPOL(1'b1), .CPHA(1'b1), .CNT_W(16)) u_dut1 (
        .sysclk_p(clk), .rst_n(rst_n), .spi_sclk_i(sclk[1]), .spi_mosi_i(mosi[1]),
        .spi_ss_i(ss[1]), .spi_rdata_o(rdata[1]), .spi_rxvalid_o(valid[1]),
        .seq_err_o(serr[1]), .rx_cnt_o(rxc[1]), .err_cnt_o(erc[1]), .LED(led[1]));

    spi_slave_rx #(.BITS_LEN(8), .CPOL(1'b0), .CPHA(1'b1), .CNT_W(16)) u_dut2 (
        .sysclk_p(clk), .rst_n(rst_n), .spi_sclk_i(sclk[2]), .spi_mosi_i(mosi[2]),
        .spi_ss_i(ss[2]), .spi_rdata_o(rdata[2]), .spi_rxvalid_o(valid[2]),
        .seq_err_o(serr[2]), .rx_cnt_o(rxc[2]), .err_cnt_o(erc[2]), .LED(led[2]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;
    int last_edge[3];

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       err;
    } exp_t;
    exp_t sbq[$];

    function automatic logic cpol_of(input int m);
        return (m == 1);
    endfunction

    function automatic logic cpha_of(input int m);
        return (m != 0);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected word
    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (valid[m]) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("unexpected_valid_inst%0d", m), 1, 0);
                end else begin
                    exp_t e;
                    int lat;
                    e = sbq.pop_front();
                    chk("valid_inst", m, e.inst);
                    chk($sformatf("rdata_inst%0d", m), int'(rdata[m]), int'(e.data));
                    chk($sformatf("led_inst%0d", m), int'(led[m]), int'(e.data));
                    chk($sformatf("seq_err_inst%0d", m), int'(serr[m]), int'(e.err));
                    lat = cyc - last_edge[m];
                    checks++;
                    if (lat != 4 && lat != 5) begin
                        errs++;
                        $display("FAIL latency_inst%0d: got %0d cycles, expected 4..5", m, lat);
                    end
                end
            end else if (serr[m]) begin
                chk($sformatf("seq_err_without_valid_inst%0d", m), 1, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int m, input logic [7:0] d, input logic e);
        exp_t x;
        x.inst = m;
        x.data = d;
        x.err  = e;
        sbq.push_back(x);
    endtask

    // Shift out the top nbits of w MSB-first; optionally release SS on the last sampling edge
    task automatic send_bits(input int m, input logic [7:0] w, input int nbits, input bit ss_last);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha_of(m)) begin
                mosi[m] = w[7 - i];
                tick(H);
                sclk[m] = ~sclk[m];
                last_edge[m] = cyc;
                if (ss_last && i == nbits - 1) ss[m] = 1'b1;
                tick(H);
                sclk[m] = ~sclk[m];
            end else begin
                sclk[m] = ~sclk[m];
                mosi[m] = w[7 - i];
                tick(H);
                sclk[m] = ~sclk[m];
                last_edge[m] = cyc;
                if (ss_last && i == nbits - 1) ss[m] = 1'b1;
                tick(H);
            end
        end
    endtask

    task automatic frame(input int m, input logic [7:0] w, input logic e, input bit ss_last);
        ss[m] = 1'b0;
        tick(H);
        push(m, w, e);
        send_bits(m, w, 8, ss_last);
        tick(H);
        ss[m] = 1'b1;
        tick(H);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tick(4);
        checks++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL drain_%s: got %0d pending words, expected 0", nm, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int m = 0; m < 3; m++) begin
            sclk[m] = cpol_of(m);
            mosi[m] = 1'b0;
            ss[m]   = 1'b1;
            last_edge[m] = 0;
        end
        #2 rst_n = 1'b0;
        tick(3);
        chk("rst_rdata",   int'(rdata[0]), 0);
        chk("rst_valid",   int'(valid[0]), 0);
        chk("rst_seq_err", int'(serr[0]),  0);
        chk("rst_rx_cnt",  int'(rxc[0]),   0);
        chk("rst_err_cnt", int'(erc[0]),   0);
        chk("rst_led",     int'(led[0]),   0);
        rst_n = 1'b1;
        tick(3);

        // Single mode-0 word
        frame(0, 8'hA5, 1'b0, 1'b0);
        drain("a5");
        chk("a5_rx_cnt",  int'(rxc[0]), 1);
        chk("a5_err_cnt", int'(erc[0]), 0);

        // Incrementing run across the 8-bit wrap; FE releases SS on its last edge
        do_reset();
        frame(0, 8'hFD, 1'b0, 1'b0);
        frame(0, 8'hFE, 1'b0, 1'b1);
        ss[0] = 1'b0;
        tick(H);
        push(0, 8'hFF, 1'b0);
        send_bits(0, 8'hFF, 8, 1'b0);
        push(0, 8'h00, 1'b0);
        send_bits(0, 8'h00, 8, 1'b0);
        push(0, 8'h01, 1'b0);
        send_bits(0, 8'h01, 8, 1'b0);
        tick(H);
        ss[0] = 1'b1;
        tick(H);
        drain("wrap");
        chk("wrap_rx_cnt",  int'(rxc[0]), 5);
        chk("wrap_err_cnt", int'(erc[0]), 0);

        // Skipped value gives exactly one sequence error
        do_reset();
        frame(0, 8'h10, 1'b0, 1'b0);
        frame(0, 8'h12, 1'b1, 1'b0);
        frame(0, 8'h13, 1'b0, 1'b0);
        drain("skip");
        chk("skip_rx_cnt",  int'(rxc[0]), 3);
        chk("skip_err_cnt", int'(erc[0]), 1);

        // Truncated word is discarded
        do_reset();
        ss[0] = 1'b0;
        tick(H);
        send_bits(0, 8'hFF, 5, 1'b0);
        tick(H);
        ss[0] = 1'b1;
        tick(2 * H);
        frame(0, 8'h3C, 1'b0, 1'b0);
        drain("trunc");
        chk("trunc_rx_cnt", int'(rxc[0]), 1);
        chk("trunc_rdata",  int'(rdata[0]), 8'h3C);

        // Asynchronous reset in the middle of a word
        ss[0] = 1'b0;
        tick(H);
        send_bits(0, 8'h55, 4, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rdata",   int'(rdata[0]), 0);
        chk("midrst_led",     int'(led[0]),   0);
        chk("midrst_rx_cnt",  int'(rxc[0]),   0);
        chk("midrst_err_cnt", int'(erc[0]),   0);
        chk("midrst_valid",   int'(valid[0]), 0);
        ss[0] = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        frame(0, 8'h77, 1'b0, 1'b0);
        drain("after_rst");
        chk("after_rst_rx_cnt",  int'(rxc[0]), 1);
        chk("after_rst_err_cnt", int'(erc[0]), 0);

        // Other SPI modes
        frame(1, 8'h5A, 1'b0, 1'b0);
        drain("mode3");
        chk("mode3_rdata", int'(rdata[1]), 8'h5A);
        frame(2, 8'hC3, 1'b0, 1'b0);
        drain("mode1");
        chk("mode1_rdata", int'(rdata[2]), 8'hC3);
        chk("mode1_rx_cnt", int'(rxc[2]), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI slave receiver that sits at the far end of the SPI link from the byte-generating master test top. It oversamples the external SCLK/MOSI/SS pins on sysclk_p and deserialises MSB-first words. It then checks that received bytes form an incrementing (mod 2^BITS_LEN) sequence and exposes the received data, counters and LED status for board-level loopback testing.

Parameters:
BITS_LEN, 8, word length in bits (2..16)
CPOL, 1'b0, SCLK idle level
CPHA, 1'b0, 0 = sample on leading edge, 1 = sample on trailing edge
CNT_W, 16, width of rx and error counters

Ports:
sysclk_p  input  1  system clock
rst_n  input  1  reset
spi_sclk_i  input  1  SPI clock pin, asynchronous to sysclk_p
spi_mosi_i  input  1  SPI data-in pin, asynchronous
spi_ss_i  input  1  slave select, active-low, asynchronous
spi_rdata_o  output  BITS_LEN  last complete received word
spi_rxvalid_o  output  1  one-cycle pulse, spi_rdata_o updated
seq_err_o  output  1  one-cycle pulse, received word != expected
rx_cnt_o  output  CNT_W  complete words received, wraps
err_cnt_o  output  CNT_W  sequence errors, saturates at all-ones
LED  output  8  spi_rdata_o[7:0], zero-extended if BITS_LEN<8

Behaviour:
- Reset rst_n, asynchronous, active-low; clock sysclk_p. All state clears on reset.
- Output reset values: all outputs 0. Synchroniser reset values: sclk = CPOL, ss = 1, mosi = 0.
- Input path: 2-flop synchronisers on sclk, mosi and ss, all of equal depth so MOSI/SCLK alignment is preserved. A registered copy of the synced sclk provides edge detection.
- Sampling edge:
  - Rising edge when CPOL^CPHA = 0.
  - Falling edge when CPOL^CPHA = 1.
  - The opposite edge is ignored; the slave has no MISO.
- Timing constraint: SCLK high and low phases must each be >= 3 sysclk_p periods; SS setup to first edge >= 3 periods.
- FSM states:
  - IDLE: synced ss = 1. Clear bit_cnt and shift register. Go to SHIFT when synced ss = 0.
  - SHIFT: on each sampling edge, shift = {shift[BITS_LEN-2:0], mosi_s} and increment bit_cnt.
    - When bit_cnt = BITS_LEN-1 at a sampling edge, go to DONE.
    - If synced ss = 1, go to IDLE and discard the partial word: no valid pulse, no counter change.
  - DONE: lasts 1 cycle.
    - spi_rdata_o <= shift; spi_rxvalid_o = 1; rx_cnt_o += 1 (wraps); run the sequence check.
    - Return to SHIFT with bit_cnt = 0 if ss is still low (back-to-back words in one SS frame), else go to IDLE.
    - A sampling edge cannot arrive in DONE, given the timing constraint.
- Latency: spi_rxvalid_o rises 4 sysclk_p cycles (+0/+1 for sync uncertainty) after the final sampling SCLK edge at the pin.
- Sequence check:
  - The first word after reset only seeds expected = word+1; no check is made.
  - After that, a mismatch against expected raises seq_err_o together with spi_rxvalid_o and increments err_cnt_o, saturating at all-ones.
  - expected is always re-seeded from the received word + 1, so a single corrupted word costs at most 2 errors.
  - Wrap: all-ones followed by 0 is correct.
- SS deassert on the same cycle as the final sampling edge: the word completes (DONE), then the FSM goes to IDLE.
- Reset mid-word: all outputs return to 0 immediately; the next full frame is received normally and re-seeds the check.

Decomposition:
- Shared package spi_pkg:
  - SPI mode constants (MODE0..MODE3 as {CPOL,CPHA}).
  - Default BITS_LEN.
  - FSM state encoding (IDLE, SHIFT, DONE).
- One sub-module: spi_sync_edge (2-flop synchroniser plus rise/fall pulse outputs, parameterised reset value), instantiated for sclk, and reused in plain synchroniser form for ss and mosi.

Test Plan:
- Mode 0, SS low, send 0xA5 (half-period 6 cycles) -> one spi_rxvalid_o pulse, spi_rdata_o = 0xA5, LED = 0xA5, rx_cnt_o = 1, err_cnt_o = 0.
- Frames 0xFD, 0xFE, 0xFF, 0x00, 0x01 (separate and back-to-back in one SS frame) -> rx_cnt_o = 5, err_cnt_o = 0, no seq_err_o.
- Frames 0x10 then 0x12 then 0x13 -> exactly one seq_err_o pulse coincident with 0x12, err_cnt_o = 1.
- SS deasserted after 5 bits, then full 0x3C -> exactly one valid pulse with 0x3C, rx_cnt_o = 1.
- rst_n pulsed low mid-word -> all outputs 0 asynchronously; next 0x77 received, no seq error.
- CPOL = 1, CPHA = 1 instance, send 0x5A -> spi_rdata_o = 0x5A. CPOL = 0, CPHA = 1 instance, send 0xC3 -> spi_rdata_o = 0xC3.
